// File: rtl/hazard_pkg.sv
// Shared execute-command encodings and the write-latency rule used by the
// hazard scoreboard and the ID stage decoder.
package hazard_pkg;

    localparam logic [3:0] CMD_NOP = 4'b0000;
    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MVN = 4'b1001;

    // Cycles a freshly issued write stays unreadable by a following instruction.
    function automatic int wb_load_val(input logic fwd, input logic is_load,
                                       input int wb_dist, input int mem_lat);
        if (!fwd)
            return wb_dist + mem_lat - 1;
        else if (is_load)
            return mem_lat;
        else
            return 0;
    endfunction

endpackage

// File: rtl/sb_counter_bank.sv
// Per-register countdown of in-flight writes: one load port with max-on-load,
// two busy read ports.
module sb_counter_bank #(
    parameter int NUM_REGS = 16,
    parameter int RW       = 4,
    parameter int CW       = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          ld,
    input  logic [RW-1:0] ld_idx,
    input  logic [CW-1:0] ld_val,
    input  logic [RW-1:0] rd1_idx,
    input  logic [RW-1:0] rd2_idx,
    output logic          rd1_busy,
    output logic          rd2_busy
);

    logic [NUM_REGS-1:0][CW-1:0] cnt;

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
        logic [CW-1:0] c;
        logic [CW-1:0] dec;

        assign dec    = (c == '0) ? '0 : c - CW'(1);
        assign cnt[r] = c;

        // Keep the longer of an older pending write and the new one.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                c <= '0;
            else if (en) begin
                if (ld && ld_idx == RW'(r))
                    c <= (ld_val > dec) ? ld_val : dec;
                else
                    c <= dec;
            end
        end
    end

    assign rd1_busy = (cnt[rd1_idx] != '0);
    assign rd2_busy = (cnt[rd2_idx] != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard detector: stalls IF/ID while a source register has a write
// in flight or a forwarding-mode change is draining.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int         NUM_REGS    = 16,
    parameter int         MEM_LATENCY = 1,
    parameter int         WB_DIST     = 2,
    parameter logic [3:0] MOV_CMD     = CMD_MOV,
    parameter logic [3:0] MVN_CMD     = CMD_MVN,
    parameter int         COUNT_W     = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        id_valid,
    input  logic [$clog2(NUM_REGS)-1:0] id_src1,
    input  logic [$clog2(NUM_REGS)-1:0] id_src2,
    input  logic                        id_two_src,
    input  logic [3:0]                  id_exec_cmd,
    input  logic                        id_wb_en,
    input  logic [$clog2(NUM_REGS)-1:0] id_dest,
    input  logic                        id_mem_r_en,
    input  logic                        freeze,
    input  logic                        has_forwarding,
    input  logic                        stall_clear,
    output logic                        hazard_detected,
    output logic                        drain_active,
    output logic [COUNT_W-1:0]          stall_count
);

    localparam int RW = $clog2(NUM_REGS);
    localparam int CW = $clog2(WB_DIST + MEM_LATENCY + 1);
    localparam logic [CW-1:0] DRAIN_LEN = CW'(WB_DIST + MEM_LATENCY - 1);

    logic          src1_used;
    logic          busy1, busy2;
    logic          issue;
    logic [CW-1:0] ld_val;
    logic [CW-1:0] drain;
    logic          mode_q;

    assign src1_used = (id_exec_cmd != MOV_CMD) && (id_exec_cmd != MVN_CMD);
    assign ld_val    = CW'(wb_load_val(has_forwarding, id_mem_r_en, WB_DIST, MEM_LATENCY));

    // Gated by rst_n so a held ID instruction cannot stall during reset.
    assign hazard_detected = rst_n && id_valid &&
                             ((src1_used && busy1) || (id_two_src && busy2) || drain != '0);
    assign issue        = id_valid && !hazard_detected && !freeze;
    assign drain_active = (drain != '0);

    sb_counter_bank #(.NUM_REGS(NUM_REGS), .RW(RW), .CW(CW)) u_bank (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (!freeze),
        .ld       (issue && id_wb_en),
        .ld_idx   (id_dest),
        .ld_val   (ld_val),
        .rd1_idx  (id_src1),
        .rd2_idx  (id_src2),
        .rd1_busy (busy1),
        .rd2_busy (busy2)
    );

    // Forwarded results were loaded with zero latency; after switching mode the
    // drain window covers them until they reach the register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain  <= '0;
            mode_q <= has_forwarding;
        end else if (!freeze) begin
            if (has_forwarding != mode_q) begin
                drain  <= DRAIN_LEN;
                mode_q <= has_forwarding;
            end else if (drain != '0) begin
                drain <= drain - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_count <= '0;
        else if (stall_clear)
            stall_count <= '0;
        else if (hazard_detected && !freeze && stall_count != '1)
            stall_count <= stall_count + COUNT_W'(1);
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Parametrised successor to the pipeline hazard detector. It keeps a per-register countdown scoreboard of in-flight writes instead of comparing against fixed EXE/MEM destination taps. This supports any data-memory latency, with or without forwarding, and adds a freeze input, a drain window on mode change and a saturating stall counter. It sits beside the ID stage, and its hazard output stalls IF/ID and injects a bubble into EXE.

Parameters:
NUM_REGS, 16, architectural registers tracked (index width RW = $clog2(NUM_REGS))
MEM_LATENCY, 1, cycles from EXE exit until load data is forwardable (1 = single-cycle MEM)
WB_DIST, 2, cycles a non-forwarded result needs before it is readable from the register file
CMD_MOV, 4'b0001, execute command that ignores src1
CMD_MVN, 4'b1001, execute command that ignores src1
COUNT_W, 16, stall counter width

Ports:
clk  in  1  clock
rst_n  in  1  reset: asynchronous, active-low
id_valid  in  1  ID holds a real instruction
id_src1  in  RW  first source register
id_src2  in  RW  second source register
id_two_src  in  1  src2 is read
id_exec_cmd  in  4  execute command of the ID instruction
id_wb_en  in  1  ID instruction writes id_dest
id_dest  in  RW  destination register
id_mem_r_en  in  1  ID instruction is a load
freeze  in  1  whole pipeline held (memory wait)
has_forwarding  in  1  forwarding unit active
stall_clear  in  1  synchronous clear of stall_count
hazard_detected  out  1  stall ID this cycle
drain_active  out  1  mode-change drain in progress
stall_count  out  COUNT_W  saturating count of hazard cycles

Behaviour:
- State: cnt[r] for each register, width CW = $clog2(WB_DIST+MEM_LATENCY+1); drain counter of width CW; registered previous mode, mode_q; stall_count.
- Reset (rst_n=0, async): all cnt = 0, drain = 0, mode_q = has_forwarding, stall_count = 0. Outputs: hazard_detected = 0 (combinational, since id_valid is ignored during reset), drain_active = 0, stall_count = 0.
- src1_used = (id_exec_cmd != CMD_MOV && id_exec_cmd != CMD_MVN). src2_used = id_two_src.
- hazard_detected (combinational, same cycle) = id_valid && ((src1_used && cnt[id_src1] != 0) || (src2_used && cnt[id_src2] != 0) || drain != 0).
- issue = id_valid && !hazard_detected && !freeze.
- Load value L on issue with id_wb_en:
  - has_forwarding = 0: L = WB_DIST + MEM_LATENCY - 1.
  - has_forwarding = 1 and load: L = MEM_LATENCY.
  - has_forwarding = 1 and not a load: L = 0.
- Each clock edge with freeze = 0:
  - every cnt[r] != 0 decrements by 1;
  - on issue with id_wb_en, cnt[id_dest] <= max(L, cnt[id_dest] - 1). The saturating max keeps an older, longer write from being hidden.
- freeze = 1: all cnt, drain and mode_q hold. hazard_detected is still evaluated. stall_count does not increment.
- Default parameters reproduce the legacy behaviour: without forwarding, a dependent instruction stalls 2 cycles; with forwarding, load-use stalls 1 cycle and ALU-use stalls 0.
- Mode change: when has_forwarding != mode_q and freeze = 0, drain <= WB_DIST + MEM_LATENCY - 1 and mode_q <= has_forwarding. Otherwise a nonzero drain decrements.
  - drain_active = (drain != 0).
  - Pending counters keep their values; drain covers forwarded results that were loaded with L = 0.
- stall_count: increments when hazard_detected && !freeze and saturates at all-ones. stall_clear has priority and sets it to 0 on the next edge.
- Register 0 is not special: every register index is tracked.
- id_valid = 0: no issue and no hazard; counters still decrement.

Decomposition:
- Shared package (hazard_pkg): CMD_MOV/CMD_MVN and the other execute-command encodings, plus the function computing L from mode and load flag. The ID stage decoder uses the same function.
- One sub-module, sb_counter_bank: NUM_REGS down-counters with a single load port and max-on-load. It owns cnt[] and exposes two read ports (src1, src2).

Test Plan:
1. Reset and forwarding off: issue ADD r1, then ADD r2,r1,r3 held in ID -> hazard_detected = 1 for exactly 2 cycles, issues on the 3rd, stall_count = 2.
2. Forwarding on, MEM_LATENCY=1: LDR r4, then SUB r5,r4 -> exactly 1 stall cycle. Repeat with ADD r4 as producer -> 0 stalls.
3. Build with MEM_LATENCY=3, forwarding on: LDR r6, then use r6 -> 3 stalls. Raise freeze for 2 cycles in the middle -> hazard still shown, total elapsed 5 cycles, stall_count = 3.
4. src1 gating: MVN r7,r8 with r8 pending -> no stall (exec_cmd 4'b1001). Same instruction with id_two_src = 0 and a pending src2 -> no stall. Set id_two_src = 1 -> stall.
5. Mode change: toggle has_forwarding 1 to 0 with no pending writes -> drain_active and hazard_detected (id_valid = 1) for 2 cycles at default parameters, then clear.
6. Assert rst_n low mid-stall with cnt[r1] = 2 -> hazard_detected drops immediately and all counters are 0. Separately, stall_count at all-ones plus a further hazard -> holds at all-ones; stall_clear -> 0.
